// File: rtl/can_bit_stuffer.sv
// CAN transmit bit stuffer.
// Takes one frame bit per bit_tick from the frame/CRC builder. After STUFF_LEN
// identical bits in the stuffed region it inserts one complementary stuff bit.
// The stuff bit also counts as the first bit of the next run.
// The TX bit sent toward the bus driver is registered.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_IDLE  | no bit launched on the last tick (bus recessive)
// ST_DATA  | a frame bit was launched on the last tick
// ST_STUFF | a stuff bit was launched on the last tick

module can_bit_stuffer #(
    parameter int STUFF_LEN = 5,
    parameter int CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             bit_tick_i,
    input  logic             in_valid_i,
    input  logic             in_bit_i,
    input  logic             in_stuff_en_i,
    output logic             in_ready_o,
    output logic             tx_bit_o,
    output logic             tx_active_o,
    output logic             stuff_pulse_o,
    output logic [CNT_W-1:0] stuff_count_o
);

    localparam int                RUN_W    = $clog2(STUFF_LEN + 1);
    localparam logic [RUN_W-1:0]  RUN_TERM = RUN_W'(STUFF_LEN);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STUFF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             last_bit_q, last_bit_d;
    logic             stuff_pending_q, stuff_pending_d;
    logic             tx_bit_q, tx_bit_d;
    logic             stuff_pulse_q, stuff_pulse_d;
    logic [CNT_W-1:0] stuff_count_q, stuff_count_d;

    logic [RUN_W-1:0] run_next;

    // A pending stuff bit owns the next tick, so upstream is stalled for exactly that tick.
    assign in_ready_o = bit_tick_i & ~stuff_pending_q & ~rst_i;

    // A run continues only when the bit repeats the last one and the frame did not break through idle.
    always_comb begin
        run_next = RUN_ONE;
        if ((in_bit_i == last_bit_q) && (state_q != ST_IDLE)) begin
            run_next = run_len_q + RUN_ONE;
        end
    end

    // Choose what the next tick sends: a stuff bit first, then a frame bit, otherwise idle recessive.
    always_comb begin
        state_d         = state_q;
        run_len_d       = run_len_q;
        last_bit_d      = last_bit_q;
        stuff_pending_d = stuff_pending_q;
        tx_bit_d        = tx_bit_q;
        stuff_pulse_d   = 1'b0;
        stuff_count_d   = stuff_count_q;

        if (bit_tick_i) begin
            if (stuff_pending_q) begin
                // The frame bit is not consumed on this tick; upstream sees in_ready low.
                tx_bit_d        = ~last_bit_q;
                state_d         = ST_STUFF;
                stuff_pulse_d   = 1'b1;
                run_len_d       = RUN_ONE;
                last_bit_d      = ~last_bit_q;
                stuff_pending_d = 1'b0;
                if (stuff_count_q != CNT_MAX) begin
                    stuff_count_d = stuff_count_q + CNT_ONE;
                end
            end else if (in_valid_i) begin
                tx_bit_d = in_bit_i;
                state_d  = ST_DATA;
                if (state_q == ST_IDLE) begin
                    // The first bit after idle starts a new frame.
                    stuff_count_d = '0;
                end
                if (in_stuff_en_i) begin
                    last_bit_d = in_bit_i;
                    if (run_next == RUN_TERM) begin
                        stuff_pending_d = 1'b1;
                        run_len_d       = '0;
                    end else begin
                        stuff_pending_d = 1'b0;
                        run_len_d       = run_next;
                    end
                end else begin
                    run_len_d       = '0;
                    stuff_pending_d = 1'b0;
                end
            end else begin
                tx_bit_d      = 1'b1;
                state_d       = ST_IDLE;
                run_len_d     = '0;
                stuff_count_d = '0;
            end
        end
    end

    // State and output registers; reset takes priority and drops any pending stuff bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            run_len_q       <= '0;
            last_bit_q      <= 1'b1;
            stuff_pending_q <= 1'b0;
            tx_bit_q        <= 1'b1;
            stuff_pulse_q   <= 1'b0;
            stuff_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            run_len_q       <= run_len_d;
            last_bit_q      <= last_bit_d;
            stuff_pending_q <= stuff_pending_d;
            tx_bit_q        <= tx_bit_d;
            stuff_pulse_q   <= stuff_pulse_d;
            stuff_count_q   <= stuff_count_d;
        end
    end

    assign tx_bit_o      = tx_bit_q;
    assign tx_active_o   = (state_q != ST_IDLE);
    assign stuff_pulse_o = stuff_pulse_q;
    assign stuff_count_o = stuff_count_q;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// Directed table-driven bench for can_bit_stuffer.
// Each vector is one bit_tick cycle followed by one tick-free cycle.
// The tick-free cycle checks that the outputs hold and that stuff_pulse drops.

module tb_can_bit_stuffer;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             bit_tick;
    logic             in_valid;
    logic             in_bit;
    logic             in_stuff_en;
    logic             in_ready;
    logic             tx_bit;
    logic             tx_active;
    logic             stuff_pulse;
    logic [CNT_W-1:0] stuff_count;

    int errors = 0;
    int checks = 0;

    can_bit_stuffer #(.STUFF_LEN(5), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .bit_tick_i    (bit_tick),
        .in_valid_i    (in_valid),
        .in_bit_i      (in_bit),
        .in_stuff_en_i (in_stuff_en),
        .in_ready_o    (in_ready),
        .tx_bit_o      (tx_bit),
        .tx_active_o   (tx_active),
        .stuff_pulse_o (stuff_pulse),
        .stuff_count_o (stuff_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       bitv;
        logic       sen;
        logic       exp_rdy;
        logic       exp_tx;
        logic       exp_act;
        logic       exp_pulse;
        logic [7:0] exp_cnt;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic v, input logic b, input logic s,
                                input logic rdy, input logic tx, input logic act,
                                input logic pl, input logic [7:0] cnt, input string tag);
        vec_t e;
        e.rst = r; e.valid = v; e.bitv = b; e.sen = s;
        e.exp_rdy = rdy; e.exp_tx = tx; e.exp_act = act; e.exp_pulse = pl; e.exp_cnt = cnt;
        e.tag = tag;
        vecs.push_back(e);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        // Reset held for three ticks.
        for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 1, 0, 0, 0, "reset");

        // 0000011 stuffed: stuff 1 after five zeros, in_ready low on 6th tick.
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s1_d1");
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s1_d2");
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s1_d3");
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s1_d4");
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s1_d5");
        add(0, 1, 1, 1, 0, 1, 1, 1, 1, "s1_stuff");
        add(0, 1, 1, 1, 1, 1, 1, 0, 1, "s1_d6");
        add(0, 1, 1, 1, 1, 1, 1, 0, 1, "s1_d7");
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, "s1_idle");

        // Eleven zeros: stuff after 5, run restarts at the stuff bit, stuff again after 5 more.
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s2_a");
        add(0, 1, 0, 1, 0, 1, 1, 1, 1, "s2_stuff1");
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 1, 0, 1, 0, 1, "s2_b");
        add(0, 1, 0, 1, 0, 1, 1, 1, 2, "s2_stuff2");
        add(0, 1, 0, 1, 1, 0, 1, 0, 2, "s2_d11");
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, "s2_idle");

        // CRC tail 0,11111 then delimiter and EOF with stuffing off.
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s3_crc0");
        for (int i = 0; i < 5; i++) add(0, 1, 1, 1, 1, 1, 1, 0, 0, "s3_crc1");
        add(0, 1, 1, 0, 0, 0, 1, 1, 1, "s3_stuff0");
        add(0, 1, 1, 0, 1, 1, 1, 0, 1, "s3_delim");
        for (int i = 0; i < 7; i++) add(0, 1, 1, 0, 1, 1, 1, 0, 1, "s3_eof");
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, "s3_idle");

        // A run of four zeros must not carry across an idle tick.
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s4_a");
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, "s4_idle");
        for (int i = 0; i < 4; i++) add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s4_b");
        add(0, 1, 1, 1, 1, 1, 1, 0, 0, "s4_one");
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, "s4_idle2");

        // Reset on the tick that would carry a stuff bit.
        for (int i = 0; i < 5; i++) add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s5_a");
        add(1, 1, 0, 1, 0, 1, 0, 0, 0, "s5_rst");
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s5_post1");
        add(0, 1, 0, 1, 1, 0, 1, 0, 0, "s5_post2");
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, "s5_idle");

        rst = 1'b1; bit_tick = 1'b0; in_valid = 1'b0; in_bit = 1'b1; in_stuff_en = 1'b0;

        foreach (vecs[i]) begin
            // Tick cycle: in_ready is combinational and checked before the edge.
            rst = vecs[i].rst; bit_tick = 1'b1; in_valid = vecs[i].valid;
            in_bit = vecs[i].bitv; in_stuff_en = vecs[i].sen;
            #1;
            check({vecs[i].tag, ".in_ready"}, i, 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk); #1;
            check({vecs[i].tag, ".tx_bit"}, i, 32'(tx_bit), 32'(vecs[i].exp_tx));
            check({vecs[i].tag, ".tx_active"}, i, 32'(tx_active), 32'(vecs[i].exp_act));
            check({vecs[i].tag, ".stuff_pulse"}, i, 32'(stuff_pulse), 32'(vecs[i].exp_pulse));
            check({vecs[i].tag, ".stuff_count"}, i, 32'(stuff_count), 32'(vecs[i].exp_cnt));

            // Tick-free cycle with changing upstream inputs: everything holds, pulse drops.
            bit_tick = 1'b0; in_valid = 1'b1; in_bit = ~vecs[i].bitv; in_stuff_en = 1'b1;
            #1;
            check({vecs[i].tag, ".hold_rdy"}, i, 32'(in_ready), 32'(0));
            @(posedge clk); #1;
            check({vecs[i].tag, ".hold_tx"}, i, 32'(tx_bit), 32'(vecs[i].exp_tx));
            check({vecs[i].tag, ".hold_act"}, i, 32'(tx_active), 32'(vecs[i].exp_act));
            check({vecs[i].tag, ".hold_pulse"}, i, 32'(stuff_pulse), 32'(0));
            check({vecs[i].tag, ".hold_cnt"}, i, 32'(stuff_count), 32'(vecs[i].exp_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
